// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder
//   Takes one quantized 8x8 block per in_valid/in_ready handshake, walks it in
//   JPEG zigzag order and emits a serial stream of (run, value) symbols:
//   DC first, then AC run/value pairs, ZRL (15,0) for each 16-zero stretch
//   that precedes a later nonzero, and EOB (0,0) when trailing zeros remain.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_matrix  [row][col] block of COEF_W-bit two's-complement coefficients
//   in_valid   in_matrix holds a block
//   in_ready   encoder is idle and can capture a block
//   sym_valid  registered symbol outputs are valid
//   sym_ready  consumer takes the current symbol
//   sym_run    number of zero coefficients preceding this symbol
//   sym_value  coefficient value (0 for ZRL and EOB)
//   sym_is_dc  symbol carries the DC coefficient
//   sym_last   final symbol of the block
module zigzag_rle_encoder #(
    parameter int COEF_W = 11,
    parameter int RUN_W  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0][7:0][COEF_W-1:0]          in_matrix,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic                                 sym_valid,
    input  logic                                 sym_ready,
    output logic [RUN_W-1:0]                     sym_run,
    output logic signed [COEF_W-1:0]             sym_value,
    output logic                                 sym_is_dc,
    output logic                                 sym_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EOB  = 2'd2
    } state_t;

    // Zigzag position -> row-major position (row*8 + col), JPEG order.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_t                     state;
    state_t                     state_next;
    logic signed [COEF_W-1:0]   blk [64];
    logic [5:0]                 idx;
    logic [RUN_W-1:0]           run;
    logic [RUN_W-1:0]           run_next;
    logic [5:0]                 last_nz;
    logic signed [COEF_W-1:0]   cur_coef;
    logic                       accept;
    logic                       advance;

    logic                       sym_load;
    logic [RUN_W-1:0]           nxt_run;
    logic signed [COEF_W-1:0]   nxt_value;
    logic                       nxt_is_dc;
    logic                       nxt_last;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    // The output register may reload when it is empty or being drained.
    assign advance  = !sym_valid || sym_ready;
    assign cur_coef = blk[idx];

    // ---- Capture: block stored already permuted into zigzag order ----
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 64; k++) begin
                blk[k] <= $signed(in_matrix[ZZ[k][5:3]][ZZ[k][2:0]]);
            end
        end
    end

    // Highest zigzag position with a nonzero AC coefficient; 0 when none.
    always_comb begin
        last_nz = '0;
        for (int k = 1; k < 64; k++) begin
            if (blk[k] != '0) begin
                last_nz = 6'(k);
            end
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (advance) begin
                    if (idx == 6'd63) begin
                        state_next = ST_IDLE;
                    end else if (idx == last_nz) begin
                        state_next = ST_EOB;
                    end
                end
            end
            ST_EOB: begin
                if (advance) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---- FSM: symbol decode for the coefficient under the scan index ----
    always_comb begin
        sym_load  = 1'b0;
        nxt_run   = '0;
        nxt_value = '0;
        nxt_is_dc = 1'b0;
        nxt_last  = 1'b0;
        run_next  = run;
        case (state)
            ST_SCAN: begin
                if (idx == 6'd0) begin
                    sym_load  = 1'b1;
                    nxt_value = cur_coef;
                    nxt_is_dc = 1'b1;
                    run_next  = '0;
                end else if (cur_coef != '0) begin
                    sym_load  = 1'b1;
                    nxt_run   = run;
                    nxt_value = cur_coef;
                    // Only reachable with a nonzero at 63, where EOB is dropped.
                    nxt_last  = (idx == 6'd63);
                    run_next  = '0;
                end else if (run == RUN_MAX && idx < last_nz) begin
                    // ZRL consumes this zero as the 16th of the stretch.
                    sym_load  = 1'b1;
                    nxt_run   = RUN_MAX;
                    run_next  = '0;
                end else begin
                    run_next  = run + 1'b1;
                end
            end
            ST_EOB: begin
                sym_load = 1'b1;
                nxt_last = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- Output register and scan counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            sym_run   <= '0;
            sym_value <= '0;
            sym_is_dc <= 1'b0;
            sym_last  <= 1'b0;
            idx       <= '0;
            run       <= '0;
        end else begin
            if (accept) begin
                idx <= '0;
                run <= '0;
            end else if (state == ST_SCAN && advance) begin
                idx <= idx + 6'd1;
                run <= run_next;
            end

            if (advance) begin
                sym_valid <= sym_load;
                if (sym_load) begin
                    sym_run   <= nxt_run;
                    sym_value <= nxt_value;
                    sym_is_dc <= nxt_is_dc;
                    sym_last  <= nxt_last;
                end
            end
        end
    end

endmodule
